// File: rtl/nn_pkg.sv
// Shared types and constants for the NN weight-loading path.
package nn_pkg;

    localparam int unsigned NN_NUM_FIFO = 16;
    localparam int unsigned NN_SEL_W    = 4;
    localparam int unsigned NN_DATA_W   = 16;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/nn_ld_counter.sv
// FIFO-select / row counter pair with wrap and last-word detection.
module nn_ld_counter
    import nn_pkg::*;
#(
    parameter int unsigned ROW_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [ROW_W-1:0]    rows,
    input  logic                adv,
    output logic [NN_SEL_W-1:0] sel,
    output logic [ROW_W-1:0]    row,
    output logic                last_c
);

    localparam logic [NN_SEL_W-1:0] SEL_MAX = NN_SEL_W'(NN_NUM_FIFO - 1);

    logic [ROW_W-1:0] last_row;

    // Select advances per accepted word; row advances when select wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            row      <= '0;
            last_row <= '0;
        end else if (clear) begin
            sel      <= '0;
            row      <= '0;
            last_row <= ROW_W'(rows - 1'b1);
        end else if (adv) begin
            sel <= NN_SEL_W'(sel + 1'b1);
            if (sel == SEL_MAX) begin
                row <= ROW_W'(row + 1'b1);
            end
        end
    end

    // The word about to be accepted is the final one of the load.
    always_comb begin
        last_c = (sel == SEL_MAX) && (row == last_row);
    end

endmodule

// File: rtl/nn_weight_loader.sv
// Round-robin sequencer feeding the 16 weight FIFOs through the write demux.
module nn_weight_loader
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = NN_DATA_W,
    parameter int unsigned NUM_OUT  = NN_NUM_FIFO,
    parameter int unsigned MAX_ROWS = 256,
    parameter int unsigned ROW_W    = $clog2(MAX_ROWS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [NUM_OUT-1:0]  fifo_full,
    output logic [NN_SEL_W-1:0] wr_sel,
    output logic                wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                done
);

    ld_state_t             state_q;
    ld_state_t             state_d;
    logic                  cnt_clear;
    logic                  hs;
    logic                  last_c;
    logic [NN_SEL_W-1:0]   sel_cnt;
    logic [ROW_W-1:0]      row_cnt;

    nn_ld_counter #(
        .ROW_W (ROW_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .rows   (num_rows),
        .adv    (hs),
        .sel    (sel_cnt),
        .row    (row_cnt),
        .last_c (last_c)
    );

    // Ready follows the targeted FIFO only; a full FIFO stalls the whole stream.
    always_comb begin
        in_ready = (state_q == LD_LOAD) && !fifo_full[sel_cnt];
        hs       = in_valid && in_ready;
    end

    // Next-state decode; the counter is cleared and num_rows latched on start.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_d   = (num_rows != '0) ? LD_LOAD : LD_DONE;
                end
            end
            LD_LOAD: begin
                if (hs && last_c) begin
                    state_d = LD_DONE;
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered write port and status; done lines up with the final wr_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= hs;
            if (hs) begin
                wr_sel  <= sel_cnt;
                wr_data <= in_data;
            end
            busy <= (state_d == LD_LOAD);
            done <= (state_d == LD_DONE);
        end
    end

    // Row count is only consumed through the last-word flag.
    logic unused_ok;
    always_comb begin
        unused_ok = ^row_cnt;
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Randomized bench for nn_weight_loader against a word-index reference model.
module tb_nn_weight_loader;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ROW_W  = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [15:0]       fifo_full;
    logic [3:0]        wr_sel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    nn_weight_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fifo_full (fifo_full),
        .wr_sel    (wr_sel),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: a load is just words k = 0 .. 16*rows-1, word k to FIFO k mod 16.
    bit          m_active;
    int          m_k;
    int          m_total;
    logic        m_wr_en;
    logic        m_done;
    logic        m_busy;
    logic [3:0]  m_sel;
    logic [15:0] m_data;

    int n_checks;
    int n_pass;
    int wr_seen;
    int done_seen;
    int busy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: check ready, clock the DUT, advance the model, check outputs.
    task automatic tick();
        logic exp_rdy;
        logic hs;
        logic idle;
        #1;
        exp_rdy = m_active && !fifo_full[m_k % 16];
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        hs   = in_valid && exp_rdy;
        idle = !m_active && !m_done;
        @(posedge clk);
        #1;
        if (reset) begin
            m_active = 0; m_k = 0; m_total = 0;
            m_wr_en = 0; m_done = 0; m_busy = 0; m_sel = '0; m_data = '0;
        end else begin
            m_wr_en = hs;
            m_done  = 0;
            if (hs) begin
                m_sel  = 4'(m_k % 16);
                m_data = in_data;
                m_k    = m_k + 1;
                if (m_k == m_total) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
            if (idle && start) begin
                if (num_rows == '0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_k      = 0;
                    m_total  = 16 * int'(num_rows);
                end
            end
            m_busy = m_active;
        end
        chk("wr_en",   32'(wr_en),   32'(m_wr_en));
        chk("done",    32'(done),    32'(m_done));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("wr_sel",  32'(wr_sel),  32'(m_sel));
        chk("wr_data", 32'(wr_data), 32'(m_data));
        if (wr_en) wr_seen = wr_seen + 1;
        if (done)  done_seen = done_seen + 1;
        if (busy)  busy_seen = busy_seen + 1;
    endtask

    // mode 0: steady; 1: toggling valid; 2: random valid/full; 3: FIFO 5 stalled 4 cycles; 4: stray start
    task automatic run_load(input int rows, input int mode, input int budget);
        int stall;
        stall     = 0;
        wr_seen   = 0;
        done_seen = 0;
        busy_seen = 0;
        num_rows  = ROW_W'(rows);
        start     = 1'b1;
        in_valid  = 1'b0;
        fifo_full = '0;
        tick();
        start = 1'b0;
        for (int c = 0; c < budget && done_seen == 0; c++) begin
            in_data   = DATA_W'($urandom);
            fifo_full = '0;
            case (mode)
                1:       in_valid = (c % 2 == 0);
                2:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            if (mode == 2) fifo_full = 16'($urandom) & 16'($urandom);
            if (mode == 3 && stall < 4 && m_k % 16 == 5) begin
                fifo_full[5] = 1'b1;
                stall = stall + 1;
            end
            start = (mode == 4 && c == 10);
            tick();
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        fifo_full = '0;
        chk("done_count", 32'(done_seen), 32'd1);
        chk("wr_count", 32'(wr_seen), 32'(16 * rows));
        if (mode == 0 || mode == 4) chk("busy_cycles", 32'(busy_seen), 32'(16 * rows));
        tick();
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_active = 0; m_k = 0; m_total = 0;
        m_wr_en = 0; m_done = 0; m_busy = 0; m_sel = '0; m_data = '0;
        reset = 1'b1; start = 1'b0; num_rows = '0;
        in_valid = 1'b0; in_data = '0; fifo_full = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // basic load, back-pressure on FIFO 5, source bubbles, zero rows, stray start
        run_load(2, 0, 200);
        run_load(1, 3, 200);
        run_load(2, 1, 200);
        run_load(0, 0, 10);
        tick();
        tick();
        run_load(2, 4, 200);

        // reset mid-load after 7 writes, then a fresh load from sel 0
        wr_seen  = 0;
        num_rows = ROW_W'(1);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && wr_seen < 7; c++) begin
            in_data = DATA_W'($urandom);
            tick();
        end
        chk("pre_reset_writes", 32'(wr_seen), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 4; c++) tick();
        chk("post_reset_writes", 32'(wr_seen), 32'd0);
        in_valid = 1'b0;
        run_load(1, 0, 200);

        // randomized loads and the maximum row count
        for (int i = 0; i < 6; i++) run_load($urandom_range(1, 4), 2, 3000);
        run_load(256, 0, 5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
